move_cmd_arbiter: RTL

//  Turns debounced direction levels (r/l/u/d) into single move commands for the board engine.

---
 rtl/game_pkg.sv | 39 +++
 rtl/rise_detect.sv | 29 ++
 rtl/move_cmd_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// ============================================================================
//  Module   : game_pkg
//  Purpose  : Direction and arbiter-state types shared with the board engine.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } arb_state_t;

    localparam int C_NUM_DIRS = 4;

    // Rise vector is indexed by direction code; lowest code wins.
    function automatic dir_t pick_dir(input logic [C_NUM_DIRS-1:0] rise);
        dir_t dir;
        if (rise[0])      dir = UP;
        else if (rise[1]) dir = DOWN;
        else if (rise[2]) dir = LEFT;
        else if (rise[3]) dir = RIGHT;
        else              dir = UP;
        return dir;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rise_detect.sv
// ============================================================================
//  Module   : rise_detect
//  Purpose  : Per-bit rising-edge detector; history resets to ones so a level
//             held through reset is never reported as a rise.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rise_detect #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] lvl_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= '1;
        else        prev_q <= lvl_i;
    end

    assign rise_o = lvl_i & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/move_cmd_arbiter.sv
// ============================================================================
//  Module   : move_cmd_arbiter
//  Purpose  : Converts debounced direction levels into single move commands
//             with valid/ready issue, done wait, timeout and release holdoff.
//             Optional auto-repeat is built when MOVE_AUTOREPEAT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_cmd_arbiter
    import game_pkg::*;
#(
    parameter int HOLDOFF_CYC = 1000,
    parameter int TIMEOUT_CYC = 65535
`ifdef MOVE_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYC  = 25000000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       r,
    input  logic       l,
    input  logic       u,
    input  logic       d,
    output logic       mv_valid,
    input  logic       mv_ready,
    output logic [1:0] mv_dir,
    input  logic       mv_done,
    output logic       busy,
    output logic       timeout_err,
    output logic [7:0] drop_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int HW = $clog2(HOLDOFF_CYC + 1);

    logic [3:0]  lvl;
    logic [3:0]  rise;
    arb_state_t  state_q, state_d;
    dir_t        dir_q, dir_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]  drop_q, drop_d;
    logic        terr_q, terr_d;

    // Bit index equals direction code.
    assign lvl = {r, l, d, u};

    rise_detect #(.W(4)) u_rise (
        .clk    (clk),
        .rst_n  (rst_n),
        .lvl_i  (lvl),
        .rise_o (rise)
    );

`ifdef MOVE_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYC + 1);
    logic [RW-1:0] rep_q, rep_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_q <= '0;
        else        rep_q <= rep_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= UP;
            timer_q <= '0;
            hold_q  <= '0;
            drop_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
            hold_q  <= hold_d;
            drop_q  <= drop_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        hold_d  = hold_q;
        drop_d  = drop_q;
        terr_d  = terr_q;
`ifdef MOVE_AUTOREPEAT_EN
        rep_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (en && (|rise)) begin
                    dir_d   = pick_dir(rise);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mv_ready) begin
                    state_d = WAIT_DONE;
                    timer_d = '0;
                end
            end
            WAIT_DONE: begin
                if (mv_done) begin
                    state_d = RELEASE;
                    hold_d  = '0;
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    terr_d  = 1'b1;
                    state_d = RELEASE;
                    hold_d  = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RELEASE: begin
                if (|lvl) begin
                    hold_d = '0;
                end else if (hold_q == HW'(HOLDOFF_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
`ifdef MOVE_AUTOREPEAT_EN
                // Only the latched direction, alone, keeps the repeat timer running.
                if (en && (lvl == (4'b0001 << dir_q))) begin
                    if (rep_q == RW'(REPEAT_CYC - 1)) begin
                        state_d = ISSUE;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && (|rise) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    assign mv_valid    = (state_q == ISSUE);
    assign mv_dir      = dir_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q;
    assign drop_cnt    = drop_q;

endmodule

`default_nettype wire
